// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: controller
// state encodings and watchdog counter width.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DSTALL = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int WD_W = 8;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall bundle between the 5-stage pipeline (master) and the stall
// sequencer (slave). The pipeline reports hazards; the sequencer returns
// register-bank enables, bubble selects and status.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             instrMemStall;
  logic             dataMemStall;
  logic             loadUse;
  logic             redirect;
  logic             halt_MW;

  logic             pcEn;
  logic             ifidEn;
  logic             idexEn;
  logic             exmemEn;
  logic             memwbEn;
  logic             ifidFlush;
  logic             idexFlush;
  logic             exmemFlush;

  logic             halted;
  logic             memTimeout;
  logic [CNT_W-1:0] stallCnt;

  modport master (
    output instrMemStall, dataMemStall, loadUse, redirect, halt_MW,
    input  pcEn, ifidEn, idexEn, exmemEn, memwbEn,
    input  ifidFlush, idexFlush, exmemFlush,
    input  halted, memTimeout, stallCnt
  );

  modport slave (
    input  instrMemStall, dataMemStall, loadUse, redirect, halt_MW,
    output pcEn, ifidEn, idexEn, exmemEn, memwbEn,
    output ifidFlush, idexFlush, exmemFlush,
    output halted, memTimeout, stallCnt
  );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
// Used for the data-stall watchdog and the optional stall counter.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, stick at all-ones; clear and reset both return to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Arbitrates data
// and instruction memory stalls, load-use hazards, control redirects and
// halt into per-cycle register enables and bubble selects.
// Optional: define PIPE_STALL_PERF_EN to build the stallCnt counter; when
// undefined stallCnt reads as zero and no counter flops exist.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int STALL_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_MAX - 1);

  state_t          state_q;
  state_t          state_d;
  logic [4:0]      en;
  logic [2:0]      flush;
  logic [WD_W-1:0] wd_q;
  logic            wd_inc;
  logic            wd_clr;
  logic            timeout_q;

  // Controller state register; reset always lands in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority arbitration: enables/flushes are zero-latency from state and
  // inputs. en = {pc, ifid, idex, exmem, memwb}, flush = {ifid, idex, exmem}.
  always_comb begin
    en      = 5'b00000;
    flush   = 3'b000;
    state_d = state_q;
    if (rst) begin
      flush   = 3'b111;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN, ST_DSTALL: begin
          if (bus.halt_MW && !bus.dataMemStall) begin
            state_d = ST_HALTED;
          end else if (bus.dataMemStall) begin
            state_d = ST_DSTALL;
          end else begin
            state_d = ST_RUN;
            if (bus.redirect) begin
              en    = 5'b11111;
              flush = 3'b111;
            end else if (bus.loadUse) begin
              en    = 5'b00111;
              flush = 3'b010;
            end else if (bus.instrMemStall) begin
              en    = 5'b01111;
              flush = 3'b100;
            end else begin
              en    = 5'b11111;
            end
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign bus.pcEn       = en[4];
  assign bus.ifidEn     = en[3];
  assign bus.idexEn     = en[2];
  assign bus.exmemEn    = en[1];
  assign bus.memwbEn    = en[0];
  assign bus.ifidFlush  = flush[2];
  assign bus.idexFlush  = flush[1];
  assign bus.exmemFlush = flush[0];
  assign bus.halted     = (state_q == ST_HALTED);

  // Every frozen data-stall cycle counts toward the watchdog, including the
  // entry cycle; any cycle without a data stall restarts it.
  assign wd_inc = bus.dataMemStall && (state_q != ST_HALTED);
  assign wd_clr = !bus.dataMemStall;

  sat_counter #(.W(WD_W)) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr),
    .inc (wd_inc),
    .q   (wd_q)
  );

  // Sticky timeout flag, set on the edge where the watchdog reaches STALL_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (wd_inc && (wd_q == WD_LAST)) begin
      timeout_q <= 1'b1;
    end
  end

  assign bus.memTimeout = timeout_q;

`ifdef PIPE_STALL_PERF_EN
  logic             stall_inc;
  logic [CNT_W-1:0] stall_q;

  assign stall_inc = !en[4] && (state_q != ST_HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (stall_inc),
    .q   (stall_q)
  );

  assign bus.stallCnt = stall_q;
`else
  assign bus.stallCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: each step drives one cycle of inputs,
// pushes the expected controls/status to a scoreboard and compares mid-cycle.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 16;

  // Control vector order: {pcEn, ifidEn, idexEn, exmemEn, memwbEn,
  //                        ifidFlush, idexFlush, exmemFlush}
  localparam logic [7:0] C_RESET  = 8'b00000_111;
  localparam logic [7:0] C_ALLEN  = 8'b11111_000;
  localparam logic [7:0] C_FROZEN = 8'b00000_000;
  localparam logic [7:0] C_REDIR  = 8'b11111_111;
  localparam logic [7:0] C_LU     = 8'b00111_010;
  localparam logic [7:0] C_IMS    = 8'b01111_100;

  // Input vector order: {instrMemStall, dataMemStall, loadUse, redirect, halt_MW}
  localparam logic [4:0] I_IDLE = 5'b00000;
  localparam logic [4:0] I_IMS  = 5'b10000;
  localparam logic [4:0] I_DMS  = 5'b01000;
  localparam logic [4:0] I_LU   = 5'b00100;
  localparam logic [4:0] I_RD   = 5'b00010;
  localparam logic [4:0] I_HALT = 5'b00001;

  typedef struct {
    string            tag;
    logic [7:0]       ctrl;
    logic             halted;
    logic             memTimeout;
    logic [CNT_W-1:0] stallCnt;
  } exp_t;

  logic clk;
  logic rst;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_sc;
  int               checks;
  int               fails;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.CNT_W(CNT_W), .STALL_MAX(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the design must show this cycle.
  task automatic applyStimulus(input string tag, input logic r, input logic [4:0] in,
                               input logic [7:0] ctrl, input logic h, input logic mt);
    exp_t e;
    rst               = r;
    bus.instrMemStall = in[4];
    bus.dataMemStall  = in[3];
    bus.loadUse       = in[2];
    bus.redirect      = in[1];
    bus.halt_MW       = in[0];
    e.tag        = tag;
    e.ctrl       = ctrl;
    e.halted     = h;
    e.memTimeout = mt;
    e.stallCnt   = exp_sc;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic checkOutput();
    exp_t       e;
    logic [7:0] obs;
    logic [1:0] st;
    e   = sb.pop_front();
    obs = {bus.pcEn, bus.ifidEn, bus.idexEn, bus.exmemEn, bus.memwbEn,
           bus.ifidFlush, bus.idexFlush, bus.exmemFlush};
    st  = {bus.halted, bus.memTimeout};
    checks++;
    assert (obs === e.ctrl) else begin
      fails++;
      $error("[TB] FAIL %s ctrl: got %b expected %b", e.tag, obs, e.ctrl);
    end
    checks++;
    assert (st === {e.halted, e.memTimeout}) else begin
      fails++;
      $error("[TB] FAIL %s halted/memTimeout: got %b expected %b", e.tag, st,
             {e.halted, e.memTimeout});
    end
    checks++;
    assert (bus.stallCnt === e.stallCnt) else begin
      fails++;
      $error("[TB] FAIL %s stallCnt: got %0d expected %0d", e.tag, bus.stallCnt, e.stallCnt);
    end
  endtask

  // One full cycle: drive, check mid-cycle, update the stall-count model, clock.
  task automatic step(input string tag, input logic r, input logic [4:0] in,
                      input logic [7:0] ctrl, input logic h, input logic mt);
    applyStimulus(tag, r, in, ctrl, h, mt);
    #4;
    checkOutput();
    if (r) begin
      exp_sc = '0;
    end else begin
`ifdef PIPE_STALL_PERF_EN
      if (!ctrl[7] && !h && (exp_sc != {CNT_W{1'b1}})) exp_sc = exp_sc + 1'b1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    exp_sc = '0;
    rst               = 1'b1;
    bus.instrMemStall = 1'b0;
    bus.dataMemStall  = 1'b0;
    bus.loadUse       = 1'b0;
    bus.redirect      = 1'b0;
    bus.halt_MW       = 1'b0;
    @(posedge clk);
    #1;

    step("reset",          1'b1, I_IDLE,               C_RESET,  1'b0, 1'b0);
    step("idle",           1'b0, I_IDLE,               C_ALLEN,  1'b0, 1'b0);
    step("loaduse",        1'b0, I_LU,                 C_LU,     1'b0, 1'b0);
    step("after_lu",       1'b0, I_IDLE,               C_ALLEN,  1'b0, 1'b0);
    step("ims_lu",         1'b0, I_IMS | I_LU,         C_LU,     1'b0, 1'b0);
    step("ims_only",       1'b0, I_IMS,                C_IMS,    1'b0, 1'b0);
    step("redirect",       1'b0, I_RD,                 C_REDIR,  1'b0, 1'b0);
    step("rd_lu_ims",      1'b0, I_RD | I_LU | I_IMS,  C_REDIR,  1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step($sformatf("dstall_rd_%0d", k), 1'b0, I_DMS | I_RD, C_FROZEN, 1'b0, 1'b0);
    end
    step("dstall_release", 1'b0, I_RD,                 C_REDIR,  1'b0, 1'b0);
    step("idle2",          1'b0, I_IDLE,               C_ALLEN,  1'b0, 1'b0);

    for (int k = 1; k <= 256; k++) begin
      step($sformatf("wd_%0d", k), 1'b0, I_DMS, C_FROZEN, 1'b0, (k >= 256));
    end
    step("wd_release",     1'b0, I_IDLE,               C_ALLEN,  1'b0, 1'b1);
    step("wd_sticky",      1'b0, I_IMS,                C_IMS,    1'b0, 1'b1);

    step("halt_rd",        1'b0, I_HALT | I_RD,        C_FROZEN, 1'b0, 1'b1);
    step("halted_ims_lu",  1'b0, I_IMS | I_LU,         C_FROZEN, 1'b1, 1'b1);
    step("halted_dms_rd",  1'b0, I_DMS | I_RD,         C_FROZEN, 1'b1, 1'b1);
    step("halted_idle",    1'b0, I_IDLE,               C_FROZEN, 1'b1, 1'b1);
    step("reset_halted",   1'b1, I_HALT,               C_RESET,  1'b1, 1'b1);
    step("post_reset",     1'b0, I_IDLE,               C_ALLEN,  1'b0, 1'b0);

    step("halt_dms",       1'b0, I_HALT | I_DMS,       C_FROZEN, 1'b0, 1'b0);
    step("halt_release",   1'b0, I_HALT,               C_FROZEN, 1'b0, 1'b0);
    step("halted2",        1'b0, I_IDLE,               C_FROZEN, 1'b1, 1'b0);
    step("reset2",         1'b1, I_IDLE,               C_RESET,  1'b1, 1'b0);
    step("dms_after_rst",  1'b0, I_DMS,                C_FROZEN, 1'b0, 1'b0);
    step("reset_dstall",   1'b1, I_DMS,                C_RESET,  1'b0, 1'b0);
    step("final_idle",     1'b0, I_IDLE,               C_ALLEN,  1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
